// File: rtl/mouse_device_sm_pkg.sv
// Shared PS/2 definitions for the host- and device-side FSMs.
// Contents:
//   ps2_state_e  - device FSM state encodings (also driven onto the debug LEDs)
//   ps2_action_e - action deferred until the command response has been sent
//   Cmd*/Resp*   - PS/2 command and response byte values
//   decode_cmd   - maps a received command byte to its deferred action
//   sat_add      - 9-bit signed saturating accumulate, returns {overflow, sum}
package mouse_device_sm_pkg;

  localparam int unsigned AccW = 9;

  typedef enum logic [3:0] {
    StSelftest = 4'h0,
    StSendAa   = 4'h1,
    StWaitAa   = 4'h2,
    StSendId   = 4'h3,
    StWaitId   = 4'h4,
    StIdle     = 4'h5,
    StSendResp = 4'h6,
    StWaitResp = 4'h7,
    StSendStat = 4'h8,
    StWaitStat = 4'h9,
    StSendDx   = 4'hA,
    StWaitDx   = 4'hB,
    StSendDy   = 4'hC,
    StWaitDy   = 4'hD
  } ps2_state_e;

  typedef enum logic [2:0] {
    ActReset,
    ActGetId,
    ActEnable,
    ActDisable,
    ActResend
  } ps2_action_e;

  localparam logic [7:0] CmdReset       = 8'hFF;
  localparam logic [7:0] CmdEnable      = 8'hF4;
  localparam logic [7:0] CmdDisable     = 8'hF5;
  localparam logic [7:0] CmdDefaults    = 8'hF6;
  localparam logic [7:0] CmdGetId       = 8'hF2;
  localparam logic [7:0] RespAck        = 8'hFA;
  localparam logic [7:0] RespResend     = 8'hFE;
  localparam logic [7:0] RespSelftestOk = 8'hAA;
  localparam logic [7:0] RespDeviceId   = 8'h00;

  function automatic ps2_action_e decode_cmd(logic [7:0] b);
    case (b)
      CmdReset:                return ActReset;
      CmdGetId:                return ActGetId;
      CmdEnable:               return ActEnable;
      CmdDisable, CmdDefaults: return ActDisable;
      default:                 return ActResend;
    endcase
  endfunction

  function automatic logic [AccW:0] sat_add(logic [AccW-1:0] acc, logic [7:0] inc);
    logic signed [AccW:0] sum;
    sum = $signed({acc[AccW-1], acc}) + $signed({{2{inc[7]}}, inc});
    if (sum > 10'sd255) begin
      return {1'b1, 9'h0FF};
    end else if (sum < -10'sd256) begin
      return {1'b1, 9'h100};
    end
    return {1'b0, sum[AccW-1:0]};
  endfunction

endpackage

// File: rtl/mouse_device_sm_if.sv
// Byte-level link between the device FSM and its PS/2 receiver/transmitter.
//   byte_rx/byte_rx_valid/byte_rx_error : received byte, valid pulse, error pulse
//   send_byte/byte_to_send              : one-cycle transmit request and its byte
//   byte_sent                           : transmitter done pulse
// master = device FSM, slave = PS/2 PHY.
interface mouse_device_sm_if;
  logic [7:0] byte_rx;
  logic       byte_rx_valid;
  logic       byte_rx_error;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent;

  modport master (
    input  byte_rx, byte_rx_valid, byte_rx_error, byte_sent,
    output send_byte, byte_to_send
  );

  modport slave (
    output byte_rx, byte_rx_valid, byte_rx_error, byte_sent,
    input  send_byte, byte_to_send
  );
endinterface

// File: rtl/mouse_motion_accum.sv
// Motion accumulator: sums dx/dy into 9-bit saturating signed accumulators with
// sticky per-axis overflow, latches buttons, and snapshots into packet registers.
//   enable_i     : accept move_valid_i (stream enabled)
//   move_*_i     : motion increment, buttons, event pulse
//   clear_i      : drop all accumulated motion
//   snap_i       : copy accumulators to packet regs and clear them this cycle
//   pending_o    : motion accumulated since last snapshot
//   pkt_*_o      : snapshot contents for the packet being sent
module mouse_motion_accum
  import mouse_device_sm_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            enable_i,
  input  logic            move_valid_i,
  input  logic [7:0]      move_dx_i,
  input  logic [7:0]      move_dy_i,
  input  logic [2:0]      buttons_i,
  input  logic            clear_i,
  input  logic            snap_i,
  output logic            pending_o,
  output logic [AccW-1:0] pkt_dx_o,
  output logic [AccW-1:0] pkt_dy_o,
  output logic            pkt_xovf_o,
  output logic            pkt_yovf_o,
  output logic [2:0]      pkt_buttons_o
);

  logic [AccW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [AccW-1:0] pkt_x_q, pkt_x_d, pkt_y_q, pkt_y_d;
  logic            xovf_q, xovf_d, yovf_q, yovf_d, pend_q, pend_d;
  logic            pkt_xovf_q, pkt_xovf_d, pkt_yovf_q, pkt_yovf_d;
  logic [2:0]      btn_q, btn_d, pkt_btn_q, pkt_btn_d;
  logic [AccW:0]   sum_x, sum_y;

  always_comb begin
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    xovf_d     = xovf_q;
    yovf_d     = yovf_q;
    btn_d      = btn_q;
    pend_d     = pend_q;
    pkt_x_d    = pkt_x_q;
    pkt_y_d    = pkt_y_q;
    pkt_xovf_d = pkt_xovf_q;
    pkt_yovf_d = pkt_yovf_q;
    pkt_btn_d  = pkt_btn_q;

    if (snap_i) begin
      pkt_x_d    = acc_x_q;
      pkt_y_d    = acc_y_q;
      pkt_xovf_d = xovf_q;
      pkt_yovf_d = yovf_q;
      pkt_btn_d  = btn_q;
      acc_x_d    = '0;
      acc_y_d    = '0;
      xovf_d     = 1'b0;
      yovf_d     = 1'b0;
      pend_d     = 1'b0;
    end

    // Accumulate on top of the (possibly just cleared) value so a move in the
    // snapshot cycle belongs to the next packet.
    sum_x = sat_add(acc_x_d, move_dx_i);
    sum_y = sat_add(acc_y_d, move_dy_i);
    if (move_valid_i && enable_i) begin
      acc_x_d = sum_x[AccW-1:0];
      acc_y_d = sum_y[AccW-1:0];
      xovf_d  = xovf_d | sum_x[AccW];
      yovf_d  = yovf_d | sum_y[AccW];
      btn_d   = buttons_i;
      pend_d  = 1'b1;
    end

    if (clear_i) begin
      acc_x_d = '0;
      acc_y_d = '0;
      xovf_d  = 1'b0;
      yovf_d  = 1'b0;
      btn_d   = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      xovf_q     <= 1'b0;
      yovf_q     <= 1'b0;
      btn_q      <= '0;
      pend_q     <= 1'b0;
      pkt_x_q    <= '0;
      pkt_y_q    <= '0;
      pkt_xovf_q <= 1'b0;
      pkt_yovf_q <= 1'b0;
      pkt_btn_q  <= '0;
    end else begin
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      xovf_q     <= xovf_d;
      yovf_q     <= yovf_d;
      btn_q      <= btn_d;
      pend_q     <= pend_d;
      pkt_x_q    <= pkt_x_d;
      pkt_y_q    <= pkt_y_d;
      pkt_xovf_q <= pkt_xovf_d;
      pkt_yovf_q <= pkt_yovf_d;
      pkt_btn_q  <= pkt_btn_d;
    end
  end

  assign pending_o     = pend_q;
  assign pkt_dx_o      = pkt_x_q;
  assign pkt_dy_o      = pkt_y_q;
  assign pkt_xovf_o    = pkt_xovf_q;
  assign pkt_yovf_o    = pkt_yovf_q;
  assign pkt_buttons_o = pkt_btn_q;

endmodule

// File: rtl/mouse_device_sm.sv
// PS/2 mouse device-side protocol FSM: self-test/ID announce, host command
// handling with FA/FE responses, and 3-byte stream packets.
//   CLK, RESET       : clock, synchronous active-high reset
//   bus (master)     : byte receive/transmit handshake with the PS/2 PHY
//   move_*_i         : motion increment, buttons {middle,right,left}, event pulse
//   stream_enabled_o : data reporting enabled
//   current_state_o  : FSM state code for debug LEDs
module mouse_device_sm
  import mouse_device_sm_pkg::*;
#(
  parameter int unsigned SELFTEST_CYCLES = 500000,
  parameter int unsigned TX_TIMEOUT      = 1000000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  mouse_device_sm_if.master        bus,
  input  logic [7:0]               move_dx_i,
  input  logic [7:0]               move_dy_i,
  input  logic [2:0]               buttons_i,
  input  logic                     move_valid_i,
  output logic                     stream_enabled_o,
  output logic [3:0]               current_state_o
);

  localparam logic [31:0] SelftestLast = 32'(SELFTEST_CYCLES - 1);
  localparam logic [31:0] TimeoutLast  = 32'(TX_TIMEOUT - 1);

  ps2_state_e  state_q, state_d, sent_next;
  ps2_action_e act_q, act_d, cmd_act_q, cmd_act_d, rx_act;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        send_q, send_d, stream_q, stream_d;
  logic        cmd_pend_q, cmd_pend_d, resend_q, resend_d;
  logic        rx_evt, wait_st, accum_clr, snap;

  logic            pending;
  logic [AccW-1:0] pkt_dx, pkt_dy;
  logic            pkt_xovf, pkt_yovf;
  logic [2:0]      pkt_btn;

  mouse_motion_accum u_accum (
    .CLK           (CLK),
    .RESET         (RESET),
    .enable_i      (stream_q),
    .move_valid_i  (move_valid_i),
    .move_dx_i     (move_dx_i),
    .move_dy_i     (move_dy_i),
    .buttons_i     (buttons_i),
    .clear_i       (accum_clr),
    .snap_i        (snap),
    .pending_o     (pending),
    .pkt_dx_o      (pkt_dx),
    .pkt_dy_o      (pkt_dy),
    .pkt_xovf_o    (pkt_xovf),
    .pkt_yovf_o    (pkt_yovf),
    .pkt_buttons_o (pkt_btn)
  );

  assign rx_evt = bus.byte_rx_valid | bus.byte_rx_error;
  assign rx_act = bus.byte_rx_error ? ActResend : decode_cmd(bus.byte_rx);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    send_d     = 1'b0;
    tx_byte_d  = tx_byte_q;
    stream_d   = stream_q;
    act_d      = act_q;
    cmd_pend_d = cmd_pend_q;
    cmd_act_d  = cmd_act_q;
    resend_d   = resend_q;
    accum_clr  = 1'b0;
    snap       = 1'b0;
    wait_st    = 1'b0;
    sent_next  = StIdle;

    // Outside IDLE a command is parked; the newest one overwrites.
    if (rx_evt && state_q != StIdle) begin
      cmd_pend_d = 1'b1;
      cmd_act_d  = rx_act;
    end

    case (state_q)
      StSelftest: begin
        if (cnt_q == SelftestLast) begin
          state_d = StSendAa;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StSendAa: begin
        send_d    = 1'b1;
        tx_byte_d = RespSelftestOk;
        cnt_d     = '0;
        state_d   = StWaitAa;
      end
      StSendId: begin
        send_d    = 1'b1;
        tx_byte_d = RespDeviceId;
        cnt_d     = '0;
        state_d   = StWaitId;
      end
      StSendResp: begin
        send_d    = 1'b1;
        tx_byte_d = (act_q == ActResend) ? RespResend : RespAck;
        cnt_d     = '0;
        state_d   = StWaitResp;
      end
      StSendStat: begin
        send_d    = 1'b1;
        tx_byte_d = {pkt_yovf, pkt_xovf, pkt_dy[AccW-1], pkt_dx[AccW-1], 1'b1, pkt_btn};
        cnt_d     = '0;
        state_d   = StWaitStat;
      end
      StSendDx: begin
        send_d    = 1'b1;
        tx_byte_d = pkt_dx[7:0];
        cnt_d     = '0;
        state_d   = StWaitDx;
      end
      StSendDy: begin
        send_d    = 1'b1;
        tx_byte_d = pkt_dy[7:0];
        cnt_d     = '0;
        state_d   = StWaitDy;
      end
      StWaitAa:   begin wait_st = 1'b1; sent_next = StSendId;   end
      StWaitId:   begin wait_st = 1'b1; sent_next = StIdle;     end
      StWaitStat: begin wait_st = 1'b1; sent_next = StSendDx;   end
      StWaitDx:   begin wait_st = 1'b1; sent_next = StSendDy;   end
      StWaitDy:   begin wait_st = 1'b1; sent_next = StIdle;     end
      StWaitResp: begin
        wait_st = 1'b1;
        case (act_q)
          ActReset:  sent_next = StSelftest;
          ActGetId:  sent_next = StSendId;
          default:   sent_next = StIdle;
        endcase
        if (bus.byte_sent) begin
          case (act_q)
            ActReset, ActDisable: begin
              stream_d  = 1'b0;
              accum_clr = 1'b1;
              resend_d  = 1'b0;
            end
            ActEnable: stream_d = 1'b1;
            default: ;
          endcase
        end
      end
      StIdle: begin
        if (cmd_pend_q) begin
          act_d      = cmd_act_q;
          cmd_pend_d = rx_evt;
          cmd_act_d  = rx_evt ? rx_act : cmd_act_q;
          state_d    = StSendResp;
        end else if (rx_evt) begin
          act_d   = rx_act;
          state_d = StSendResp;
        end else if (stream_q && (pending || resend_q)) begin
          // A timed-out packet is resent from the held snapshot; fresh motion
          // stays in the accumulator for the following packet.
          snap     = ~resend_q;
          resend_d = 1'b0;
          state_d  = StSendStat;
        end
      end
      default: begin
        state_d = StSelftest;
        cnt_d   = '0;
      end
    endcase

    if (wait_st) begin
      if (bus.byte_sent) begin
        state_d = sent_next;
        cnt_d   = '0;
      end else if (cnt_q == TimeoutLast) begin
        state_d = StIdle;
        cnt_d   = '0;
        if (state_q inside {StWaitStat, StWaitDx, StWaitDy}) resend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StSelftest;
      cnt_q      <= '0;
      send_q     <= 1'b0;
      tx_byte_q  <= 8'h00;
      stream_q   <= 1'b0;
      act_q      <= ActResend;
      cmd_pend_q <= 1'b0;
      cmd_act_q  <= ActResend;
      resend_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      send_q     <= send_d;
      tx_byte_q  <= tx_byte_d;
      stream_q   <= stream_d;
      act_q      <= act_d;
      cmd_pend_q <= cmd_pend_d;
      cmd_act_q  <= cmd_act_d;
      resend_q   <= resend_d;
    end
  end

  assign bus.send_byte     = send_q;
  assign bus.byte_to_send  = tx_byte_q;
  assign stream_enabled_o  = stream_q;
  assign current_state_o   = state_q;

endmodule

// File: tb/tb_mouse_device_sm.sv
// Scoreboard bench for mouse_device_sm: stimulus pushes expected transmit bytes,
// a monitor pops/compares on every SEND_BYTE, a responder models the transmitter.
module tb_mouse_device_sm;

  localparam int unsigned TxDelay = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] move_dx = '0, move_dy = '0;
  logic [2:0] buttons = '0;
  logic       move_valid = 1'b0;
  logic       stream;
  logic [3:0] cur_state;
  logic       withhold = 1'b0, resp_sent = 1'b0, man_sent = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  mouse_device_sm_if bus ();
  assign bus.byte_sent = resp_sent | man_sent;

  mouse_device_sm #(
    .SELFTEST_CYCLES (16),
    .TX_TIMEOUT      (40)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .bus              (bus),
    .move_dx_i        (move_dx),
    .move_dy_i        (move_dy),
    .buttons_i        (buttons),
    .move_valid_i     (move_valid),
    .stream_enabled_o (stream),
    .current_state_o  (cur_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every transmit request must match the next expected byte.
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.send_byte === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_send: got %0h expected nothing", bus.byte_to_send);
        end else begin
          check("tx_byte", {24'd0, bus.byte_to_send}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Transmitter model: acknowledge each byte after TxDelay cycles.
  initial begin
    forever begin
      @(negedge CLK);
      if (bus.send_byte === 1'b1 && !withhold) begin
        repeat (TxDelay) @(negedge CLK);
        resp_sent = 1'b1;
        @(negedge CLK);
        resp_sent = 1'b0;
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic err, input bit chk_lat);
    int n;
    @(negedge CLK);
    bus.byte_rx       = b;
    bus.byte_rx_valid = ~err;
    bus.byte_rx_error = err;
    @(negedge CLK);
    bus.byte_rx_valid = 1'b0;
    bus.byte_rx_error = 1'b0;
    if (chk_lat) begin
      n = 1;
      while (bus.send_byte !== 1'b1 && n < 20) begin
        @(negedge CLK);
        n++;
      end
      check("rx_to_send_latency", n, 2);
    end
  endtask

  task automatic move(input logic [7:0] dx, input logic [7:0] dy, input logic [2:0] btn);
    @(negedge CLK);
    move_dx    = dx;
    move_dy    = dy;
    buttons    = btn;
    move_valid = 1'b1;
    @(negedge CLK);
    move_valid = 1'b0;
  endtask

  task automatic pulse_sent();
    @(negedge CLK);
    man_sent = 1'b1;
    @(negedge CLK);
    man_sent = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (10) @(negedge CLK);
  endtask

  task automatic wait_state(input logic [3:0] st, input int bound);
    int n = 0;
    while (cur_state !== st && n < bound) begin
      @(negedge CLK);
      n++;
    end
    check("wait_state_reached", {28'd0, cur_state}, {28'd0, st});
  endtask

  initial begin
    int n;
    bus.byte_rx       = '0;
    bus.byte_rx_valid = 1'b0;
    bus.byte_rx_error = 1'b0;

    // Reset state and power-up announce AA, 00 after 16 self-test cycles.
    repeat (3) @(negedge CLK);
    check("rst_state", {28'd0, cur_state}, 32'd0);
    check("rst_send", {31'd0, bus.send_byte}, 32'd0);
    check("rst_byte", {24'd0, bus.byte_to_send}, 32'd0);
    check("rst_stream", {31'd0, stream}, 32'd0);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h00);
    RESET = 1'b0;
    n = 0;
    while (bus.send_byte !== 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check("selftest_latency", n, 17);
    drain(200);
    check("idle_after_boot", {28'd0, cur_state}, 32'h5);

    // Reset command: FA then full self-test announce.
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h00);
    send_rx(8'hFF, 1'b0, 1'b1);
    drain(200);
    check("idle_after_ff", {28'd0, cur_state}, 32'h5);

    // Get ID.
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'h00);
    send_rx(8'hF2, 1'b0, 1'b1);
    drain(100);

    // Enable streaming.
    exp_q.push_back(8'hFA);
    send_rx(8'hF4, 1'b0, 1'b1);
    drain(100);
    check("stream_on", {31'd0, stream}, 32'd1);

    // dx=+5 dy=-3 left button.
    exp_q.push_back(8'h29);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'hFD);
    move(8'd5, 8'hFD, 3'b001);
    drain(100);

    // Three dx=+100 accumulate while the FA is in flight -> X saturates.
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    withhold = 1'b1;
    send_rx(8'hF4, 1'b0, 1'b1);
    move(8'd100, 8'd0, 3'b000);
    move(8'd100, 8'd0, 3'b000);
    move(8'd100, 8'd0, 3'b000);
    pulse_sent();
    withhold = 1'b0;
    drain(100);
    repeat (20) @(negedge CLK);
    // Accumulators were cleared: a small move yields a clean packet.
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    move(8'd1, 8'd0, 3'b000);
    drain(100);

    // F5 during WAIT_DX: packet completes, then FA, streaming off.
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'hFA);
    move(8'd3, 8'd4, 3'b000);
    wait_state(4'hB, 100);
    send_rx(8'hF5, 1'b0, 1'b0);
    drain(100);
    check("stream_off_f5", {31'd0, stream}, 32'd0);

    // Receive error and unknown command both answer FE.
    exp_q.push_back(8'hFE);
    send_rx(8'h00, 1'b1, 1'b1);
    drain(100);
    exp_q.push_back(8'hFE);
    send_rx(8'h12, 1'b0, 1'b1);
    drain(100);
    check("stream_still_off", {31'd0, stream}, 32'd0);

    // Motion while disabled is dropped; enabling must not emit a packet.
    move(8'd7, 8'd0, 3'b000);
    exp_q.push_back(8'hFA);
    send_rx(8'hF4, 1'b0, 1'b1);
    drain(100);
    repeat (20) @(negedge CLK);
    check("stream_on_again", {31'd0, stream}, 32'd1);

    // Status byte timeout: back to IDLE, then the same packet is resent.
    withhold = 1'b1;
    exp_q.push_back(8'h08);
    move(8'd2, 8'd0, 3'b000);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("first_stat_seen", exp_q.size(), 0);
    withhold = 1'b0;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    drain(300);

    // Reset mid-byte: handshake abandoned, stray BYTE_SENT ignored.
    withhold = 1'b1;
    exp_q.push_back(8'hFA);
    send_rx(8'hF2, 1'b0, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("midrst_state", {28'd0, cur_state}, 32'd0);
    check("midrst_byte", {24'd0, bus.byte_to_send}, 32'd0);
    check("midrst_stream", {31'd0, stream}, 32'd0);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h00);
    RESET = 1'b0;
    pulse_sent();
    check("selftest_ignores_sent", {28'd0, cur_state}, 32'd0);
    withhold = 1'b0;
    drain(200);
    check("idle_after_midrst", {28'd0, cur_state}, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/mouse_device_sm.md
MOUSE_DEVICE_SM -- requirements
Module: mouse_device_sm

Interface
REQ-001 SHALL have parameter SELFTEST_CYCLES, default 500000, meaning self-test delay before AA (10 ms at 50 MHz).
REQ-002 SHALL have parameter TX_TIMEOUT, default 1000000, meaning max cycles waiting on BYTE_SENT.
REQ-003 CLK  in  1  system clock; all logic on posedge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 BYTE_RX  in  8  byte from device-side PS/2 receiver.
REQ-006 BYTE_RX_VALID  in  1  one-cycle pulse, BYTE_RX valid.
REQ-007 BYTE_RX_ERROR  in  1  one-cycle pulse, parity/framing error on received byte.
REQ-008 SEND_BYTE  out  1  one-cycle request to device-side transmitter.
REQ-009 BYTE_TO_SEND  out  8  byte to transmit; stable from SEND_BYTE until BYTE_SENT.
REQ-010 BYTE_SENT  in  1  one-cycle pulse, transmitter finished byte.
REQ-011 MOVE_DX, MOVE_DY  in  8 each  signed two's-complement motion increment.
REQ-012 BUTTONS  in  3  {middle, right, left} level inputs.
REQ-013 MOVE_VALID  in  1  one-cycle pulse, motion/button event.
REQ-014 STREAM_ENABLED  out  1  data reporting enabled (after F4).
REQ-015 CURRENT_STATE  out  4  FSM state encoding, for debug LEDs.

Function
REQ-016 States SHALL be: 0 SELFTEST, 1 SEND_AA, 2 WAIT_AA, 3 SEND_ID, 4 WAIT_ID, 5 IDLE, 6 SEND_RESP, 7 WAIT_RESP, 8 SEND_STAT, 9 WAIT_STAT, A SEND_DX, B WAIT_DX, C SEND_DY, D WAIT_DY; unused codes -> SELFTEST.
REQ-017 SELFTEST SHALL count SELFTEST_CYCLES then enter SEND_AA; counter cleared on entry.
REQ-018 Each SEND_x state SHALL pulse SEND_BYTE for exactly one cycle with BYTE_TO_SEND = AA / 00 / response / status / dx / dy, then go to matching WAIT_x.
REQ-019 Each WAIT_x SHALL advance on BYTE_SENT: WAIT_AA->SEND_ID, WAIT_ID->IDLE, WAIT_STAT->SEND_DX, WAIT_DX->SEND_DY, WAIT_DY->IDLE, WAIT_RESP->per pending action (REQ-022).
REQ-020 Any WAIT_x exceeding TX_TIMEOUT cycles without BYTE_SENT SHALL go to IDLE, keeping pending motion.
REQ-021 In IDLE, BYTE_RX_VALID SHALL decode: FF reset, F4 enable, F5 disable, F6 defaults, F2 get-ID -> response FA; any other byte -> response FE; BYTE_RX_ERROR -> response FE.
REQ-022 Pending action after response: FF -> clear STREAM_ENABLED and accumulators, enter SELFTEST; F2 -> SEND_ID; F4 -> set STREAM_ENABLED, IDLE; F5/F6 -> clear STREAM_ENABLED and accumulators, IDLE; FE -> IDLE.
REQ-023 Command received in any non-IDLE state SHALL be latched (one-deep, newest wins) and serviced on next IDLE entry, taking priority over packet start; in-flight byte always completes.
REQ-024 In IDLE with no command latched, STREAM_ENABLED=1 and motion pending SHALL enter SEND_STAT.
REQ-025 MOVE_VALID SHALL add MOVE_DX/MOVE_DY into 9-bit signed accumulators, saturating at -256/+255; BUTTONS latched; motion-pending flag set; ignored while STREAM_ENABLED=0.
REQ-026 On SEND_STAT entry, accumulators SHALL be snapshotted into packet registers and cleared in the same cycle; a simultaneous MOVE_VALID SHALL land in the cleared accumulator.
REQ-027 Status byte SHALL be {Yovf, Xovf, Ysign, Xsign, 1, middle, right, left}; overflow set when accumulator was saturated; dx/dy bytes = low 8 bits of snapshot.
REQ-028 Latency: SEND_BYTE asserts exactly 2 cycles after the BYTE_SENT/BYTE_RX_VALID that triggered the state change.

Reset
REQ-029 RESET SHALL set state SELFTEST, counters 0, SEND_BYTE 0, BYTE_TO_SEND 00, STREAM_ENABLED 0, accumulators/pending/latched command cleared, CURRENT_STATE 0.
REQ-030 RESET mid-byte SHALL abandon the handshake; a later BYTE_SENT in SELFTEST SHALL be ignored.

Structure
REQ-031 State encodings and PS/2 command/response constants (FF, F4, F5, F6, F2, FA, FE, AA, 00) SHALL live in a shared package used by host and device FSMs.
REQ-032 Motion accumulator with saturation and snapshot SHALL be sub-module mouse_motion_accum.

Verification
REQ-033 Reset, SELFTEST_CYCLES=16 -> SEND_BYTE with AA at ~cycle 17, 00 after BYTE_SENT, then IDLE.
REQ-034 RX FF -> FA, AA, 00; RX F4 -> FA and STREAM_ENABLED=1.
REQ-035 Streaming, MOVE_VALID dx=+5 dy=-3 buttons=001 -> bytes 29, 05, FD.
REQ-036 Three MOVE_VALID dx=+100 -> status X overflow set, dx byte FF; accumulators cleared after.
REQ-037 RX F5 during WAIT_DX -> DX/DY finish, then FA, STREAM_ENABLED=0; RX_ERROR in IDLE -> FE.
REQ-038 BYTE_SENT withheld in WAIT_STAT for TX_TIMEOUT -> IDLE, packet resent on next opportunity.
